// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle core controller: FSM states, opcodes,
// ALU class codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    WB_R,
    WB_I,
    WB_MEM,
    BRANCH,
    JUMP,
    HALT
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_ORI  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_J    = 4'b0110;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [1:0] ALU_RTYPE = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main sequencer of the multi-cycle RISC core: walks fetch/decode/execute/
// memory/writeback phases and drives every datapath enable and mux select.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic       halted
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Outputs decode purely from state (plus the few Mealy terms), so an
  // asynchronous reset to IDLE clears every strobe without a clock edge.
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALU_RTYPE;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_ONE;
        alu_op    = ALU_ADD;
        pc_src    = PC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = DECODE;
      end
      DECODE: begin
        alu_src_b = SRCB_SEXT;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_R:             w_next = EXEC_R;
          OP_LW, OP_SW:     w_next = MEM_ADDR;
          OP_BEQ:           w_next = BRANCH;
          OP_ORI, OP_ADDI:  w_next = EXEC_I;
          OP_J:             w_next = JUMP;
          OP_HLT:           w_next = HALT;
          default: begin
            w_next     = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = ALU_RTYPE;
        w_next    = WB_R;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        if (opcode == OP_ORI) begin
          alu_src_b = SRCB_ZEXT;
          alu_op    = ALU_OR;
        end else begin
          alu_src_b = SRCB_SEXT;
          alu_op    = ALU_ADD;
        end
        w_next = WB_I;
      end
      WB_I: begin
        reg_write = 1'b1;
        w_next    = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
        alu_op    = ALU_ADD;
        w_next    = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next = WB_MEM;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next = FETCH;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = zero;
        w_next    = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
        w_next   = FETCH;
      end
      HALT: halted = 1'b1;
      default: w_next = IDLE;
    endcase
  end

endmodule
